uart_tx_fsm: RTL
================

# uart_tx_fsm

Serial transmitter for the UART block: the transmit-side counterpart of the oversampled receiver. It accepts one parallel byte per frame and shifts out start bit, 8 data bits LSB-first, optional parity, and stop bit on `TX_OUT`. Each bit is held for `Prescale` clock cycles, so it runs on the same oversampled UART clock and configuration registers as the receiver.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `PRESCALE_WIDTH`, 6: width of the `Prescale` port.
- `CLK` in 1: UART clock, rising edge.
- `nRESET` in 1: reset, synchronous, active-low. One clock; no other clock domain.
- `P_DATA` in `DATA_WIDTH`: byte to send.
- `DATA_VALID` in 1: request. Accepted only in IDLE.
- `PAR_EN` in 1: 1 = parity bit present.
- `PAR_TYP` in 1: 0 = even, 1 = odd.
- `Prescale` in `PRESCALE_WIDTH`: cycles per bit. Legal range is 4..63.
- `TX_OUT` out 1: serial line, registered.
- `Busy` out 1: frame in progress, registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **Reset** (sampled low on an edge): state = IDLE, `TX_OUT`=1, `Busy`=0, edge counter = 0, bit counter = 0, shift register = 0. Any frame in progress is aborted at once, with no stop bit.
- **IDLE**: `TX_OUT`=1, `Busy`=0.
  - If `DATA_VALID`=1 at an edge, that edge latches `P_DATA`, `PAR_EN` and `Prescale`.
  - The same edge latches the parity bit, computed as XOR-reduce(`P_DATA`) XOR `PAR_TYP`.
  - State → START, `TX_OUT`←0, `Busy`←1.
- **Edge counter**: counts 0..latched `Prescale`−1 in every non-IDLE state. A bit ends when the count equals `Prescale`−1; the counter then wraps to 0.
- **START**: `TX_OUT`=0 for one bit period, then → DATA with `TX_OUT`←data[0].
- **DATA**:
  - Bit counter runs 0..7.
  - At each bit end, send the next data bit.
  - After bit 7 ends: go to PARITY (`TX_OUT`←parity) if latched `PAR_EN`=1, otherwise to STOP (`TX_OUT`←1).
- **PARITY**: one bit period, then → STOP with `TX_OUT`←1.
- **STOP**: `TX_OUT`=1 for one bit period. At bit end → IDLE with `Busy`←0.
- **Requests while busy**: `DATA_VALID` is ignored while not in IDLE. The source must hold the request or re-issue it; nothing is queued.
- **Input changes mid-frame**: changes to `P_DATA`, `PAR_EN`, `PAR_TYP` or `Prescale` during a frame have no effect on that frame.
- **Illegal prescale**: `Prescale` below 4 is illegal. The behaviour is then defined only as: a bit lasts max(`Prescale`,1) cycles, and the FSM never hangs.

## Timing
- **Acceptance**: edge k samples `DATA_VALID`=1 in IDLE. `TX_OUT` goes low and `Busy` goes high in the cycle after edge k, so latency is 1 cycle.
- **Frame length**: (10 + `PAR_EN`) × `Prescale` cycles, measured from edge k to the edge where `Busy` falls.
- **Back-to-back frames**:
  - `Busy` falls at the end of the stop bit, and the FSM spends at least one IDLE cycle with `TX_OUT`=1.
  - If `DATA_VALID` is high in that cycle, the next start bit begins one cycle later.
  - The minimum inter-frame gap is therefore stop bit + 1 cycle.
- **Reset during a frame**: the next edge with `nRESET`=0 forces `TX_OUT`=1 and `Busy`=0. A request present on the first edge after reset is released is accepted normally.
- **Glitch-free output**: `TX_OUT` changes only at bit boundaries.

## Structure
- **Shared UART package/include**:
  - state encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit)
  - `DATA_WIDTH`
  - `PRESCALE_WIDTH`
  - parity-type constants (`PAR_EVEN`=0, `PAR_ODD`=1)
  
  The receiver uses the same package.
- **Sub-module `uart_tx_bit_timer`**:
  - edge counter and bit counter
  - inputs: enable, latched prescale, clear
  - outputs: `bit_done` and `bit_cnt`
- **FSM body** contains the shift register, parity latch and output registers.

## Test plan
- **Reset values**: hold `nRESET`=0 for 3 cycles with `DATA_VALID`=1 → `TX_OUT`=1, `Busy`=0 throughout; nothing is sent.
- **No parity**: `P_DATA`=0xA5, `PAR_EN`=0, `Prescale`=8.
  - `TX_OUT`, 8 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - `Busy` high for exactly 80 cycles, starting 1 cycle after acceptance.
- **Parity, both types**: `P_DATA`=0x01, `PAR_EN`=1, `Prescale`=4.
  - `PAR_TYP`=0 → parity bit 1; `PAR_TYP`=1 → parity bit 0.
  - Frame lasts 44 cycles.
- **Inputs held high and changed mid-frame**: `DATA_VALID` held high for the whole test, `P_DATA` switched from 0x3C to 0xFF at cycle 20.
  - First frame carries 0x3C.
  - Exactly one IDLE cycle, then a second frame carrying 0xFF.
  - Changing `Prescale` mid-frame does not alter the bit length of the current frame.
- **Reset during a frame**: assert `nRESET`=0 during data bit 3 → `TX_OUT`=1 and `Busy`=0 in the cycle after the reset edge. After release, a new 0x5A frame transmits correctly.
- **Prescale boundaries**: `Prescale`=4 and `Prescale`=63 with 0x00 → bit widths are exactly 4 and 63 cycles; the edge counter wraps to 0 at each bit boundary.

Source files
------------

// File: rtl/uart_tx_fsm_pkg.sv
// Shared UART definitions: state encodings, default widths and parity-type constants.
// The receiver imports this same package.
package uart_tx_fsm_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int PRESCALE_WIDTH = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // Parity bit for a byte: even parity gives XOR-reduce, odd parity inverts it.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic par_typ);
    return (^data) ^ par_typ;
  endfunction

endpackage

// File: rtl/uart_tx_fsm_bit_timer.sv
// Bit timer: edge counter that marks the end of each bit period, plus a
// bit counter that advances once per completed bit.
module uart_tx_fsm_bit_timer #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_enable,
  input  logic                      i_clear,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit_done,
  output logic [BIT_CNT_WIDTH-1:0]  o_bit_cnt
);

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic [BIT_CNT_WIDTH-1:0]  r_bit_cnt;
  logic [PRESCALE_WIDTH:0]   w_cnt_plus1;
  logic                      w_last;

  // A bit ends when count+1 reaches the prescale; prescale 0 or 1 both give
  // one-cycle bits, so the timer can never stall on an illegal value.
  assign w_cnt_plus1 = {1'b0, r_edge_cnt} + 1'b1;
  assign w_last      = (w_cnt_plus1 >= {1'b0, i_prescale});
  assign o_bit_done  = i_enable & w_last;
  assign o_bit_cnt   = r_bit_cnt;

  // Edge counter: runs 0..prescale-1 while enabled, wraps at each bit end.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear || !i_enable) begin
      r_edge_cnt <= '0;
    end else if (w_last) begin
      r_edge_cnt <= '0;
    end else begin
      r_edge_cnt <= w_cnt_plus1[PRESCALE_WIDTH-1:0];
    end
  end

  // Bit counter: steps once per completed bit, cleared by the FSM on entry to DATA.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear || !i_enable) begin
      r_bit_cnt <= '0;
    end else if (o_bit_done) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional
// parity, stop bit. Each bit lasts the prescale latched at frame acceptance.
// Handshake: a request (DATA_VALID=1) is taken only on an edge where the FSM
// is IDLE; that edge latches data, parity enable/type and prescale. Busy rises
// the cycle after acceptance and falls after the stop bit. Requests while Busy
// are dropped, never queued.
module uart_tx_fsm #(
  parameter int DATA_WIDTH     = uart_tx_fsm_pkg::DATA_WIDTH,
  parameter int PRESCALE_WIDTH = uart_tx_fsm_pkg::PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      nRESET,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy,
  output logic [2:0]                o_state
);

  import uart_tx_fsm_pkg::*;

  localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

  uart_state_t               r_state;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_par_bit;
  logic                      r_par_en;
  logic [PRESCALE_WIDTH-1:0] r_prescale;

  logic                      w_enable;
  logic                      w_clear;
  logic                      w_bit_done;
  logic [BIT_CNT_WIDTH-1:0]  w_bit_cnt;

  // The timer runs in every non-IDLE state; leaving START restarts the bit
  // counter so DATA counts its bits from zero.
  assign w_enable = (r_state != ST_IDLE);
  assign w_clear  = (r_state == ST_START) && w_bit_done;
  assign o_state  = r_state;

  uart_tx_fsm_bit_timer #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
  ) u_bit_timer (
    .i_clk      (CLK),
    .i_rst_n    (nRESET),
    .i_enable   (w_enable),
    .i_clear    (w_clear),
    .i_prescale (r_prescale),
    .o_bit_done (w_bit_done),
    .o_bit_cnt  (w_bit_cnt)
  );

  // Frame FSM with registered line and busy outputs; TX_OUT only moves at bit ends.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_prescale <= '0;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          if (DATA_VALID) begin
            r_shift    <= P_DATA;
            r_par_en   <= PAR_EN;
            r_prescale <= Prescale;
            r_par_bit  <= calc_parity(P_DATA, PAR_TYP);
            r_state    <= ST_START;
            TX_OUT     <= 1'b0;
            Busy       <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_done) begin
            TX_OUT  <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            if (w_bit_cnt == LAST_BIT) begin
              if (r_par_en) begin
                TX_OUT  <= r_par_bit;
                r_state <= ST_PARITY;
              end else begin
                TX_OUT  <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              TX_OUT  <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (w_bit_done) begin
            TX_OUT  <= 1'b1;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            TX_OUT  <= 1'b1;
            Busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
